// File: rtl/asi_pkg.sv
// rtl/asi_pkg.sv - shared AXI burst types and constants for the AR splitter
package asi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } split_state_t;

  localparam int unsigned FOUR_KB    = 4096;
  // log2 of the byte lane count for the default 128-bit data bus
  localparam int unsigned BYTES_LOG2 = 4;

endpackage

// File: rtl/asi_flag_fifo.sv
// rtl/asi_flag_fifo.sv - 1-bit synchronous FIFO holding per-sub-burst "parent last" flags
module asi_flag_fifo #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head    = mem[rd_ptr[PW-1:0]];
  assign do_pop  = pop & ~empty;
  // a pop frees the slot the push needs when both land on a full FIFO
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (PW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (PW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/asi_ar_split.sv
// rtl/asi_ar_split.sv - splits INCR read bursts at 4KB / MAX_BEATS and merges RLAST back
module asi_ar_split
  import asi_pkg::*;
#(
  parameter int AXI_DW     = 128,
  parameter int AXI_AW     = 40,
  parameter int AXI_IW     = 8,
  parameter int AXI_LW     = 8,
  parameter int AXI_SW     = 3,
  parameter int AXI_BURSTW = 2,
  parameter int AXI_RRESPW = 2,
  parameter int MAX_BEATS  = 256,
  parameter int SPL_FD     = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [AXI_IW-1:0]     S_ARID,
  input  logic [AXI_AW-1:0]     S_ARADDR,
  input  logic [AXI_LW-1:0]     S_ARLEN,
  input  logic [AXI_SW-1:0]     S_ARSIZE,
  input  logic [AXI_BURSTW-1:0] S_ARBURST,
  input  logic                  S_ARVALID,
  output logic                  S_ARREADY,
  output logic [AXI_IW-1:0]     S_RID,
  output logic [AXI_DW-1:0]     S_RDATA,
  output logic [AXI_RRESPW-1:0] S_RRESP,
  output logic                  S_RLAST,
  output logic                  S_RVALID,
  input  logic                  S_RREADY,
  output logic [AXI_IW-1:0]     M_ARID,
  output logic [AXI_AW-1:0]     M_ARADDR,
  output logic [AXI_LW-1:0]     M_ARLEN,
  output logic [AXI_SW-1:0]     M_ARSIZE,
  output logic [AXI_BURSTW-1:0] M_ARBURST,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  input  logic [AXI_IW-1:0]     M_RID,
  input  logic [AXI_DW-1:0]     M_RDATA,
  input  logic [AXI_RRESPW-1:0] M_RRESP,
  input  logic                  M_RLAST,
  input  logic                  M_RVALID,
  output logic                  M_RREADY
);

  localparam int RW = AXI_LW + 1;
  localparam logic [AXI_SW-1:0] SIZE_MAX = AXI_SW'($clog2(AXI_DW/8));

  split_state_t          state_q, state_d;
  logic                  arready_q;
  logic [AXI_IW-1:0]     id_q;
  logic [AXI_AW-1:0]     addr_q;
  logic [AXI_SW-1:0]     size_q;
  logic [AXI_BURSTW-1:0] burst_q;
  logic [RW-1:0]         rem_q;

  logic [AXI_AW-1:0] bpb, abase, to4k, n_full;
  logic [RW-1:0]     n;
  logic              pass_thru, last_sub;
  logic              s_hs, ar_hs, in_split;
  logic              fifo_head, fifo_full, fifo_empty, fifo_pop;

  // sub-burst length from the current cursor; pass-through issues the remainder whole
  always_comb begin
    pass_thru = (burst_q != AXI_BURSTW'(BURST_INCR)) || (size_q > SIZE_MAX);
    bpb       = AXI_AW'(1) << size_q;
    abase     = addr_q & ~(bpb - AXI_AW'(1));
    to4k      = (AXI_AW'(FOUR_KB) - {{(AXI_AW-12){1'b0}}, abase[11:0]}) >> size_q;
    n_full    = AXI_AW'(rem_q);
    if (!pass_thru) begin
      if (to4k < n_full) n_full = to4k;
      if (AXI_AW'(MAX_BEATS) < n_full) n_full = AXI_AW'(MAX_BEATS);
    end
    n        = n_full[RW-1:0];
    last_sub = (rem_q == n);
  end

  assign in_split  = (state_q == ST_SPLIT);
  assign S_ARREADY = arready_q;
  assign M_ARVALID = in_split & ~fifo_full;
  assign M_ARID    = in_split ? id_q : '0;
  assign M_ARADDR  = in_split ? addr_q : '0;
  assign M_ARLEN   = in_split ? AXI_LW'(n - RW'(1)) : '0;
  assign M_ARSIZE  = in_split ? size_q : '0;
  assign M_ARBURST = in_split ? burst_q : '0;

  assign s_hs  = S_ARVALID & arready_q;
  assign ar_hs = M_ARVALID & M_ARREADY;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (s_hs) state_d = ST_SPLIT;
      ST_SPLIT: if (ar_hs && last_sub) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= (state_d == ST_IDLE);
      if (s_hs) begin
        id_q    <= S_ARID;
        addr_q  <= S_ARADDR;
        size_q  <= S_ARSIZE;
        burst_q <= S_ARBURST;
        rem_q   <= RW'(S_ARLEN) + RW'(1);
      end else if (ar_hs) begin
        addr_q <= abase + (n_full << size_q);
        rem_q  <= rem_q - n;
      end
    end
  end

  asi_flag_fifo #(.DEPTH(SPL_FD)) u_flag_fifo (
    .clk       (ACLK),
    .rst_n     (ARESETn),
    .push      (ar_hs),
    .push_data (last_sub),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // R merge: only the sub-burst flagged as the parent's last keeps its RLAST
  assign S_RID    = M_RID;
  assign S_RDATA  = M_RDATA;
  assign S_RRESP  = M_RRESP;
  assign S_RVALID = M_RVALID;
  assign M_RREADY = S_RREADY;
  assign S_RLAST  = M_RLAST & (fifo_empty | fifo_head);
  assign fifo_pop = M_RVALID & S_RREADY & M_RLAST;

endmodule
